// File: rtl/ecall_unit_if.sv
// Ecall handshake bundle between the CPU controller and the ecall responder.
// The controller (master) drives the request and register operands; the
// responder (slave) returns the done strobe and the a0 write-back.
interface ecall_unit_if;
    logic        ecall;
    logic [31:0] a7;
    logic [31:0] a0;
    logic        ecall_done;
    logic        reg_wen;
    logic [31:0] reg_wdata;

    modport master (
        output ecall, a7, a0,
        input  ecall_done, reg_wen, reg_wdata
    );

    modport slave (
        input  ecall, a7, a0,
        output ecall_done, reg_wen, reg_wdata
    );
endinterface

// File: rtl/ecall_unit.sv
// Ecall responder: decodes the service number in a7 and prints an integer to
// the display latch, reads the switches after a confirm press, or halts.
// Optional macro ECALL_DEBOUNCE_EN adds a stable-level debounce counter on the
// synchronized confirm button (DEBOUNCE_CYCLES consecutive differing cycles).
module ecall_unit #(
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw_i,
    input  logic                btn_confirm_i,
    ecall_unit_if.slave         bus,
    output logic [31:0]         disp_data_o,
    output logic                disp_valid_o,
    output logic                waiting_input_o,
    output logic                halted_o
);

    localparam logic [31:0] SVC_PRINT_INT = 32'd1;
    localparam logic [31:0] SVC_READ_INT  = 32'd5;
    localparam logic [31:0] SVC_EXIT      = 32'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT_PRESS,
        S_DONE,
        S_HALT
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
    logic                btn_s1_q, btn_s2_q;
    logic                btn_level;
    logic                btn_prev_q;
    logic                btn_rise;

    // Two-flop synchronizers for the asynchronous switches and button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            sw_s1_q  <= sw_i;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn_confirm_i;
            btn_s2_q <= btn_s1_q;
        end
    end

`ifdef ECALL_DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt_q;
    logic            btn_cond_q;

    // Accept a new button level only after it has been stable long enough;
    // any return to the current level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_q   <= '0;
            btn_cond_q <= 1'b0;
        end else if (btn_s2_q == btn_cond_q) begin
            db_cnt_q   <= '0;
        end else if (db_cnt_q >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_cond_q <= btn_s2_q;
            db_cnt_q   <= '0;
        end else begin
            db_cnt_q   <= db_cnt_q + DB_W'(1);
        end
    end

    assign btn_level = btn_cond_q;
`else
    assign btn_level = btn_s2_q;
`endif

    // Previous conditioned level, tracked continuously so a button already
    // held on entry to WAIT_PRESS never looks like a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev_q <= 1'b0;
        end else begin
            btn_prev_q <= btn_level;
        end
    end

    assign btn_rise = btn_level & ~btn_prev_q;

    // ------------------------------------------------------------------
    // Service FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] a7_q, a7_d;
    logic [31:0] a0_q, a0_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic        disp_valid_q, disp_valid_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic        ecall_done_q, ecall_done_d;
    logic        reg_wen_q, reg_wen_d;
    logic        waiting_q, waiting_d;
    logic        halted_q, halted_d;

    // Next-state and next-output decode; everything holds unless changed.
    always_comb begin
        state_d      = state_q;
        a7_d         = a7_q;
        a0_d         = a0_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        reg_wdata_d  = reg_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ecall) begin
                    a7_d    = bus.a7;
                    a0_d    = bus.a0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (a7_q == SVC_PRINT_INT) begin
                    disp_data_d  = a0_q;
                    disp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else if (a7_q == SVC_READ_INT) begin
                    state_d = S_WAIT_PRESS;
                end else if (a7_q == SVC_EXIT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_PRESS: begin
                // A dropped request means the pipeline was flushed.
                if (!bus.ecall) begin
                    state_d = S_IDLE;
                end else if (btn_rise) begin
                    reg_wdata_d = 32'(sw_s2_q);
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ecall_done_d = (state_d == S_DONE);
        reg_wen_d    = (state_q == S_WAIT_PRESS) && (state_d == S_DONE);
        waiting_d    = (state_d == S_WAIT_PRESS);
        halted_d     = halted_q | (state_d == S_HALT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            a7_q         <= '0;
            a0_q         <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            reg_wdata_q  <= '0;
            ecall_done_q <= 1'b0;
            reg_wen_q    <= 1'b0;
            waiting_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            a7_q         <= a7_d;
            a0_q         <= a0_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            reg_wdata_q  <= reg_wdata_d;
            ecall_done_q <= ecall_done_d;
            reg_wen_q    <= reg_wen_d;
            waiting_q    <= waiting_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.ecall_done  = ecall_done_q;
    assign bus.reg_wen     = reg_wen_q;
    assign bus.reg_wdata   = reg_wdata_q;
    assign disp_data_o     = disp_data_q;
    assign disp_valid_o    = disp_valid_q;
    assign waiting_input_o = waiting_q;
    assign halted_o        = halted_q;

endmodule

// File: tb/tb_ecall_unit.sv
// Directed bench for ecall_unit: table of non-blocking services plus
// hand-written read, held-button, abort, reset and exit sequences.
module tb_ecall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        btn;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        waiting_input;
    logic        halted;

    always #5 clk = ~clk;

    ecall_unit_if bus ();

    ecall_unit #(
        .SW_WIDTH        (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sw_i            (sw),
        .btn_confirm_i   (btn),
        .bus             (bus),
        .disp_data_o     (disp_data),
        .disp_valid_o    (disp_valid),
        .waiting_input_o (waiting_input),
        .halted_o        (halted)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a7;
        logic [31:0] a0;
        logic [31:0] exp_disp;
        logic        exp_valid;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait up to 'bound' negedges for ecall_done; lat=-1 on timeout.
    task automatic wait_done(input int bound, output int lat, output logic wen,
                             output logic [31:0] wdata);
        lat   = -1;
        wen   = 1'b0;
        wdata = '0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (bus.ecall_done) begin
                lat   = i;
                wen   = bus.reg_wen;
                wdata = bus.reg_wdata;
                break;
            end
        end
    endtask

    // Wait up to 'bound' negedges for waiting_input; returns cycles or -1.
    task automatic wait_waiting(input int bound, output int lat);
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (waiting_input) begin
                lat = i;
                break;
            end
        end
    endtask

    // Issue a non-blocking service, scramble operands after capture, and
    // check latency, strobe width and write-enable.
    task automatic run_simple(input string tag, input logic [31:0] a7, input logic [31:0] a0);
        int          lat;
        logic        wen;
        logic [31:0] wd;
        bus.a7    = a7;
        bus.a0    = a0;
        bus.ecall = 1'b1;
        @(negedge clk);
        bus.a7 = 32'd5;
        bus.a0 = ~a0;
        wait_done(10, lat, wen, wd);
        chk({tag, " latency"}, 32'(lat < 0 ? -1 : lat + 1), 32'd2);
        chk({tag, " wen at done"}, 32'(wen), 32'd0);
        bus.ecall = 1'b0;
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'(bus.ecall_done), 32'd0);
    endtask

    initial begin
        int          lat;
        int          done_cnt;
        logic        wen;
        logic [31:0] wd;

        vt[0] = '{a7: 32'd1,          a0: 32'hDEAD_BEEF, exp_disp: 32'hDEAD_BEEF, exp_valid: 1'b1};
        vt[1] = '{a7: 32'd99,         a0: 32'h1234_5678, exp_disp: 32'hDEAD_BEEF, exp_valid: 1'b1};
        vt[2] = '{a7: 32'd1,          a0: 32'h0000_0042, exp_disp: 32'h0000_0042, exp_valid: 1'b1};
        vt[3] = '{a7: 32'd0,          a0: 32'hFFFF_FFFF, exp_disp: 32'h0000_0042, exp_valid: 1'b1};
        vt[4] = '{a7: 32'h8000_0001,  a0: 32'h0BAD_CAFE, exp_disp: 32'h0000_0042, exp_valid: 1'b1};

        rst       = 1'b0;
        bus.ecall = 1'b0;
        bus.a7    = '0;
        bus.a0    = '0;
        sw        = '0;
        btn       = 1'b0;
        cyc(3);
        chk("reset done",    32'(bus.ecall_done), 32'd0);
        chk("reset wen",     32'(bus.reg_wen),    32'd0);
        chk("reset wdata",   bus.reg_wdata,       32'd0);
        chk("reset disp",    disp_data,           32'd0);
        chk("reset valid",   32'(disp_valid),     32'd0);
        chk("reset waiting", 32'(waiting_input),  32'd0);
        chk("reset halted",  32'(halted),         32'd0);
        rst = 1'b1;
        cyc(2);

        // Table: print and unknown services.
        for (int k = 0; k < 5; k++) begin
            run_simple($sformatf("vec%0d", k), vt[k].a7, vt[k].a0);
            chk($sformatf("vec%0d disp", k),   disp_data,       vt[k].exp_disp);
            chk($sformatf("vec%0d valid", k),  32'(disp_valid), 32'(vt[k].exp_valid));
            chk($sformatf("vec%0d halted", k), 32'(halted),     32'd0);
            chk($sformatf("vec%0d wdata", k),  bus.reg_wdata,   32'd0);
            cyc(1);
        end

        // Read integer with a clean press.
        sw        = 16'h00A5;
        bus.a7    = 32'd5;
        bus.a0    = 32'h0;
        bus.ecall = 1'b1;
        wait_waiting(10, lat);
        chk("read waiting latency", 32'(lat), 32'd2);
        cyc(3);
        chk("read still waiting", 32'(waiting_input),  32'd1);
        chk("read no early done", 32'(bus.ecall_done), 32'd0);
        btn = 1'b1;
        wait_done(10, lat, wen, wd);
        chk("read done seen", 32'(lat > 0), 32'd1);
        chk("read wen",       32'(wen),     32'd1);
        chk("read wdata",     wd,           32'h0000_00A5);
        chk("read waiting at done", 32'(waiting_input), 32'd0);
        bus.ecall = 1'b0;
        @(negedge clk);
        chk("read done one cycle", 32'(bus.ecall_done), 32'd0);
        chk("read wen one cycle",  32'(bus.reg_wen),    32'd0);
        chk("read wdata holds",    bus.reg_wdata,       32'h0000_00A5);
        cyc(5);
        btn = 1'b0;
        cyc(10);

        // Button already held when the read starts.
        btn = 1'b1;
        cyc(10);
        sw        = 16'h1234;
        bus.ecall = 1'b1;
        wait_done(15, lat, wen, wd);
        chk("held no completion", 32'(lat), 32'hFFFF_FFFF);
        chk("held waiting", 32'(waiting_input), 32'd1);
        btn = 1'b0;
        wait_done(10, lat, wen, wd);
        chk("release no completion", 32'(lat), 32'hFFFF_FFFF);
        sw  = 16'h5A5A;
        btn = 1'b1;
        wait_done(12, lat, wen, wd);
        chk("repress done seen", 32'(lat > 0), 32'd1);
        chk("repress wen",       32'(wen),     32'd1);
        chk("repress wdata",     wd,           32'h0000_5A5A);
        bus.ecall = 1'b0;
        cyc(2);
        btn = 1'b0;
        cyc(10);

        // Abort a read by dropping ecall.
        bus.a7    = 32'd5;
        bus.ecall = 1'b1;
        wait_waiting(10, lat);
        chk("abort waiting", 32'(lat > 0), 32'd1);
        bus.ecall = 1'b0;
        done_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ecall_done || bus.reg_wen) done_cnt++;
        end
        chk("abort no done",  32'(done_cnt),       32'd0);
        chk("abort idle led", 32'(waiting_input),  32'd0);
        chk("abort wdata",    bus.reg_wdata,       32'h0000_5A5A);
        run_simple("post abort", 32'd1, 32'h0000_0777);
        chk("post abort disp", disp_data, 32'h0000_0777);

        // Reset in the middle of a read.
        bus.a7    = 32'd5;
        bus.ecall = 1'b1;
        wait_waiting(10, lat);
        chk("rst wait entered", 32'(lat > 0), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async rst waiting", 32'(waiting_input),  32'd0);
        chk("async rst valid",   32'(disp_valid),     32'd0);
        chk("async rst disp",    disp_data,           32'd0);
        chk("async rst wdata",   bus.reg_wdata,       32'd0);
        chk("async rst done",    32'(bus.ecall_done), 32'd0);
        bus.ecall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(1);
        run_simple("post rst", 32'd1, 32'hCAFE_F00D);
        chk("post rst disp",  disp_data,       32'hCAFE_F00D);
        chk("post rst valid", 32'(disp_valid), 32'd1);

        // Exit service.
        bus.a7    = 32'd10;
        bus.a0    = 32'd0;
        bus.ecall = 1'b1;
        lat       = -1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (halted) begin
                lat = i;
                break;
            end
        end
        chk("exit halt latency", 32'(lat), 32'd2);
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ecall_done) done_cnt++;
        end
        chk("exit no done",     32'(done_cnt), 32'd0);
        chk("exit halt sticky", 32'(halted),   32'd1);
        #2 rst = 1'b0;
        #1;
        chk("exit rst clears halt", 32'(halted), 32'd0);
        bus.ecall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
